// File: rtl/seq_mult_booth_param_if.sv
// Operand/result bundle for seq_mult_booth_param: start/is_signed/a/b in, busy/done/product out.
// Latency: none (wires only). Backpressure: none; the requester must watch busy/done.
interface seq_mult_booth_param_if #(
    parameter int WIDTH = 6
);
    logic                 start;
    logic                 is_signed;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   product;

    modport master (
        output start, is_signed, a, b,
        input  busy, done, product
    );

    modport slave (
        input  start, is_signed, a, b,
        output busy, done, product
    );
endinterface

// File: rtl/seq_mult_booth_param.sv
// Radix-2 Booth sequential multiplier, signed or unsigned per operation, one step per clock.
// Latency: done pulses WIDTH+1 cycles after the start edge (data-dependent if SEQ_MULT_EARLY_EXIT_EN).
// Backpressure: start is ignored while busy; product holds until the next completion or reset.
module seq_mult_booth_param #(
    parameter int WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    seq_mult_booth_param_if.slave bus
);
    localparam int XW = WIDTH + 1;
    localparam int AW = WIDTH + 2;
    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH + 2);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         state, state_nxt;
    logic [AW-1:0]  acc, acc_nxt;
    logic [XW-1:0]  q, q_nxt;
    logic [XW-1:0]  m, m_nxt;
    logic           q_m1, q_m1_nxt;
    logic [CW-1:0]  cnt, cnt_nxt;
    logic [PW-1:0]  product_r, product_nxt;

    logic [AW-1:0]  m_ext;
    logic [AW-1:0]  sum;
    logic [AW-1:0]  step_acc;
    logic [XW-1:0]  step_q;
    logic           step_qm1;
    logic [CW-1:0]  cnt_dec;
    logic           last;
    logic [PW-1:0]  result;
    logic [XW-1:0]  a_ext;
    logic [XW-1:0]  b_ext;

`ifdef SEQ_MULT_EARLY_EXIT_EN
    logic signed [AW+XW-1:0] full;
    logic [XW-1:0]           mask;
    logic                    exit_now;
`endif

    // One Booth step: add/subtract M by the recoded pair, then arithmetic shift of {ACC,Q,q_m1}.
    always_comb begin
        m_ext = {m[XW-1], m};
        case ({q[0], q_m1})
            2'b01:   sum = acc + m_ext;
            2'b10:   sum = acc - m_ext;
            default: sum = acc;
        endcase
        step_acc = {sum[AW-1], sum[AW-1:1]};
        step_q   = {sum[0], q[XW-1:1]};
        step_qm1 = q[0];
        cnt_dec  = cnt - CW'(1);
`ifdef SEQ_MULT_EARLY_EXIT_EN
        // Once every unconsumed multiplier bit and q_m1 is zero, the remaining steps are pure shifts.
        full     = {step_acc, step_q};
        mask     = ~({XW{1'b1}} << cnt_dec);
        exit_now = ((step_q & mask) == '0) && !step_qm1;
        last     = exit_now || (cnt_dec == '0);
        result   = PW'(full >>> cnt_dec);
`else
        last     = (cnt_dec == '0);
        result   = {step_acc[WIDTH-2:0], step_q};
`endif
    end

    always_comb begin
        a_ext = {bus.is_signed & bus.a[WIDTH-1], bus.a};
        b_ext = {bus.is_signed & bus.b[WIDTH-1], bus.b};
    end

    always_comb begin
        state_nxt   = state;
        acc_nxt     = acc;
        q_nxt       = q;
        q_m1_nxt    = q_m1;
        m_nxt       = m;
        cnt_nxt     = cnt;
        product_nxt = product_r;
        case (state)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_nxt = RUN;
                    acc_nxt   = '0;
                    q_nxt     = b_ext;
                    q_m1_nxt  = 1'b0;
                    m_nxt     = a_ext;
                    cnt_nxt   = CW'(WIDTH + 1);
                end else begin
                    state_nxt = IDLE;
                end
            end
            RUN: begin
                acc_nxt  = step_acc;
                q_nxt    = step_q;
                q_m1_nxt = step_qm1;
                cnt_nxt  = cnt_dec;
                if (last) begin
                    state_nxt   = DONE;
                    product_nxt = result;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            acc       <= '0;
            q         <= '0;
            q_m1      <= 1'b0;
            m         <= '0;
            cnt       <= '0;
            product_r <= '0;
        end else begin
            state     <= state_nxt;
            acc       <= acc_nxt;
            q         <= q_nxt;
            q_m1      <= q_m1_nxt;
            m         <= m_nxt;
            cnt       <= cnt_nxt;
            product_r <= product_nxt;
        end
    end

    assign bus.busy    = (state == RUN);
    assign bus.done    = (state == DONE);
    assign bus.product = product_r;
endmodule

// File: tb/tb_seq_mult_booth_param.sv
// Bench for seq_mult_booth_param (WIDTH=6): directed and random operations against an arithmetic model.
module tb_seq_mult_booth_param;
    localparam int W = 6;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    seq_mult_booth_param_if #(.WIDTH(W)) bus ();

    seq_mult_booth_param #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] model(input logic sg, input logic [5:0] av, input logic [5:0] bv);
        int x;
        int y;
        int p;
        x = sg ? {{26{av[5]}}, av} : {26'b0, av};
        y = sg ? {{26{bv[5]}}, bv} : {26'b0, bv};
        p = x * y;
        return p[11:0];
    endfunction

    // Cycles from the start edge to the done pulse.
    function automatic int exp_lat(input logic sg, input logic [5:0] bv);
`ifdef SEQ_MULT_EARLY_EXIT_EN
        logic [6:0] eb;
        eb = {sg & bv[5], bv};
        for (int k = 1; k <= W + 1; k++)
            if ((eb >> (k - 1)) == 7'd0) return k;
        return W + 1;
`else
        return W + 1;
`endif
    endfunction

    task automatic do_op(input logic sg, input logic [5:0] av, input logic [5:0] bv,
                         input int disturb, input string tag);
        logic [11:0] expv;
        int          cyc;
        expv = model(sg, av, bv);
        bus.start     = 1'b1;
        bus.is_signed = sg;
        bus.a         = av;
        bus.b         = bv;
        @(posedge clk); #1;
        bus.start = 1'b0;
        chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
        cyc = 0;
        while (!bus.done && cyc < 30) begin
            if (disturb != 0 && cyc == disturb) begin
                bus.start     = 1'b1;
                bus.a         = 6'($urandom);
                bus.b         = 6'($urandom);
                bus.is_signed = ~sg;
            end else begin
                bus.start = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        bus.start = 1'b0;
        chk({tag, "_lat"}, 32'(cyc), 32'(exp_lat(sg, bv)));
        chk({tag, "_prod"}, 32'(bus.product), 32'(expv));
        @(posedge clk); #1;
        chk({tag, "_pulse"}, 32'(bus.done), 32'd0);
        chk({tag, "_hold"}, 32'(bus.product), 32'(expv));
    endtask

    initial begin
        int cyc;
        int cyc2;
        bus.start     = 1'b0;
        bus.is_signed = 1'b0;
        bus.a         = '0;
        bus.b         = '0;

        #12;
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_prod", 32'(bus.product), 32'd0);
        #1 rst = 1'b1;
        @(posedge clk); #1;

        do_op(1'b0, 6'd2, 6'd2, 0, "u2x2");
        chk("u2x2_const", 32'(bus.product), 32'h004);
        do_op(1'b0, 6'd17, 6'd16, 0, "u17x16");
        do_op(1'b0, 6'b110001, 6'b101011, 0, "u49x43");
        chk("u49x43_const", 32'(bus.product), 32'h83B);
        do_op(1'b1, 6'b110001, 6'b101011, 0, "s_m15xm21");
        chk("s_m15xm21_const", 32'(bus.product), 32'h13B);
        do_op(1'b1, 6'b100000, 6'b011111, 0, "s_m32x31");
        chk("s_m32x31_const", 32'(bus.product), 32'hC20);
        do_op(1'b0, 6'd63, 6'd63, 0, "u63x63");
        chk("u63x63_const", 32'(bus.product), 32'hF81);
        do_op(1'b1, 6'b100000, 6'b100000, 0, "s_m32xm32");
        chk("s_m32xm32_const", 32'(bus.product), 32'h400);
        do_op(1'b0, 6'd0, 6'd37, 0, "u_a0");
        do_op(1'b1, 6'd45, 6'd0, 0, "s_b0");
        do_op(1'b0, 6'd45, 6'd0, 0, "u_b0");
        do_op(1'b0, 6'd29, 6'd1, 0, "u_b1");
        do_op(1'b1, 6'd29, 6'b111111, 0, "s_bm1");

        // start pulsed mid-operation with different operands must be ignored
        do_op(1'b0, 6'd5, 6'b100111, 3, "ignore");

        for (int i = 0; i < 40; i++)
            do_op(1'($urandom), 6'($urandom), 6'($urandom), 0, "rand");

        // Back-to-back: start held high through DONE
        bus.start     = 1'b1;
        bus.is_signed = 1'b0;
        bus.a         = 6'd9;
        bus.b         = 6'd11;
        @(posedge clk); #1;
        cyc = 0;
        while (!bus.done && cyc < 30) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("b2b_lat1", 32'(cyc), 32'(exp_lat(1'b0, 6'd11)));
        chk("b2b_prod1", 32'(bus.product), 32'(model(1'b0, 6'd9, 6'd11)));
        bus.is_signed = 1'b1;
        bus.a         = 6'b111001;
        bus.b         = 6'd13;
        cyc2 = 0;
        do begin
            @(posedge clk); #1;
            cyc2++;
        end while (!bus.done && cyc2 < 30);
        bus.start = 1'b0;
        chk("b2b_gap", 32'(cyc2), 32'(exp_lat(1'b1, 6'd13) + 1));
        chk("b2b_prod2", 32'(bus.product), 32'(model(1'b1, 6'b111001, 6'd13)));
        @(posedge clk); #1;
        chk("b2b_idle", 32'(bus.done), 32'd0);

        // Reset in the middle of RUN aborts with no done pulse
        bus.start     = 1'b1;
        bus.is_signed = 1'b0;
        bus.a         = 6'd37;
        bus.b         = 6'd50;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("arst_busy", 32'(bus.busy), 32'd0);
        chk("arst_done", 32'(bus.done), 32'd0);
        chk("arst_prod", 32'(bus.product), 32'd0);
        repeat (2) begin
            @(posedge clk); #1;
            chk("arst_hold_done", 32'(bus.done), 32'd0);
        end
        rst = 1'b1;
        repeat (10) begin
            @(posedge clk); #1;
            chk("post_rst_no_done", 32'(bus.done), 32'd0);
        end
        chk("post_rst_prod", 32'(bus.product), 32'd0);
        do_op(1'b1, 6'b101101, 6'd22, 0, "post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
